// File: rtl/pat_gen_pkg.sv
// rtl/pat_gen_pkg.sv - shared types, register indices and bit positions for the pattern generator
package pat_gen_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_WALK  = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int REG_CTRL   = 0;
  localparam int REG_SEED   = 1;
  localparam int REG_COUNT  = 2;
  localparam int REG_STATUS = 3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_MODE_LSB   = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

endpackage

// File: rtl/pat_gen_seq.sv
// rtl/pat_gen_seq.sv - combinational next-word function for the pattern generator
module pat_gen_seq
  import pat_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  pat_mode_e              mode,
  input  logic [DATA_WIDTH-1:0]  cur,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic [DATA_WIDTH-1:0]  taps,
  output logic [DATA_WIDTH-1:0]  next
);

  always_comb begin
    next = seed;
    case (mode)
      MODE_CONST: next = seed;
      MODE_INCR:  next = cur + DATA_WIDTH'(1);
      MODE_LFSR:  next = cur[0] ? ((cur >> 1) ^ taps) : (cur >> 1);
      MODE_WALK:  next = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1]};
      default:    next = seed;
    endcase
  end

endmodule

// File: rtl/wb_pat_gen_core.sv
// rtl/wb_pat_gen_core.sv - Wishbone-slave pattern generator with register bank and handshaked output
module wb_pat_gen_core
  import pat_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    NUM_REGS   = 4,
  parameter int                    SEL_WIDTH  = DATA_WIDTH / 8,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 16'hB400
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wb_si_cyc_i,
  input  logic                  wb_si_stb_i,
  input  logic                  wb_si_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_si_adr_i,
  input  logic [SEL_WIDTH-1:0]  wb_si_sel_i,
  input  logic [DATA_WIDTH-1:0] wb_si_dat_i,
  output logic [DATA_WIDTH-1:0] wb_si_dat_o,
  output logic                  wb_si_ack_o,
  input  logic                  cfg_pat_gen_i,
  output logic [DATA_WIDTH-1:0] pat_data_o,
  output logic                  pat_valid_o,
  input  logic                  pat_ready_i,
  output logic                  nopg_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]      idx;
  logic                  addr_ok, sel_status, bus_req, bus_wr;
  logic                  done_sts, run_en, handshake, fin_evt, cont_lat;
  logic [DATA_WIDTH-1:0] wr_merged, rd_val, status_word, start_word, next_word;
  logic [DATA_WIDTH-1:0] seed_lat, remaining;
  pat_mode_e             mode_lat, ctrl_mode;
  state_e                state;
  logic                  unused_adr;

  assign unused_adr = ^wb_si_adr_i[1:0];
  assign idx        = wb_si_adr_i[IDX_W+1:2];
  assign addr_ok    = ((wb_si_adr_i >> (IDX_W + 2)) == '0) && (32'(idx) < NUM_REGS);
  assign sel_status = (32'(idx) == REG_STATUS);
  assign bus_req    = wb_si_cyc_i && wb_si_stb_i && !wb_si_ack_o;
  assign bus_wr     = bus_req && wb_si_we_i && addr_ok;

  assign run_en    = regs[REG_CTRL][CTRL_EN_BIT];
  assign ctrl_mode = pat_mode_e'(regs[REG_CTRL][CTRL_MODE_LSB +: 2]);
  assign handshake = pat_valid_o && pat_ready_i;
  // Final word of a counted run: remaining is about to reach zero
  assign fin_evt   = (state == ST_RUN) && run_en && handshake && !cont_lat &&
                     (remaining == DATA_WIDTH'(1));
  assign nopg_o    = !((state == ST_RUN) && (pat_valid_o || cfg_pat_gen_i));

  always_comb begin
    wr_merged = regs[idx];
    for (int b = 0; b < SEL_WIDTH; b++) begin
      if (wb_si_sel_i[b]) wr_merged[8*b +: 8] = wb_si_dat_i[8*b +: 8];
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_BUSY_BIT] = (state == ST_RUN);
    status_word[STATUS_DONE_BIT] = done_sts;
  end

  always_comb begin
    rd_val = '0;
    if (addr_ok) rd_val = sel_status ? status_word : regs[idx];
  end

  always_comb begin
    start_word = regs[REG_SEED];
    case (ctrl_mode)
      MODE_WALK: start_word = DATA_WIDTH'(1);
      MODE_LFSR: if (regs[REG_SEED] == '0) start_word = DATA_WIDTH'(1);
      default:   start_word = regs[REG_SEED];
    endcase
  end

  pat_gen_seq #(.DATA_WIDTH(DATA_WIDTH)) u_seq (
    .mode (mode_lat),
    .cur  (pat_data_o),
    .seed (seed_lat),
    .taps (LFSR_TAPS),
    .next (next_word)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_si_ack_o <= 1'b0;
      wb_si_dat_o <= '0;
    end else begin
      wb_si_ack_o <= bus_req;
      if (bus_req && !wb_si_we_i) wb_si_dat_o <= rd_val;
    end
  end

  // Completion overrides both a same-cycle W1C of DONE and a bus write to CTRL
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      done_sts <= 1'b0;
    end else begin
      if (bus_wr && !sel_status) regs[idx] <= wr_merged;
      if (bus_wr && sel_status && wb_si_sel_i[0] && wb_si_dat_i[STATUS_DONE_BIT])
        done_sts <= 1'b0;
      if (fin_evt) begin
        done_sts <= 1'b1;
        regs[REG_CTRL][CTRL_EN_BIT] <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      pat_valid_o <= 1'b0;
      pat_data_o  <= '0;
      remaining   <= '0;
      seed_lat    <= '0;
      mode_lat    <= MODE_CONST;
      cont_lat    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run_en) begin
            state       <= ST_RUN;
            pat_valid_o <= 1'b1;
            pat_data_o  <= start_word;
            remaining   <= regs[REG_COUNT];
            seed_lat    <= regs[REG_SEED];
            mode_lat    <= ctrl_mode;
            cont_lat    <= (regs[REG_COUNT] == '0);
          end
        end
        ST_RUN: begin
          if (!run_en) begin
            state       <= ST_IDLE;
            pat_valid_o <= 1'b0;
          end else if (handshake) begin
            if (fin_evt) begin
              state       <= ST_DONE;
              pat_valid_o <= 1'b0;
            end else begin
              pat_data_o  <= next_word;
              pat_valid_o <= cfg_pat_gen_i;
            end
            if (!cont_lat) remaining <= remaining - DATA_WIDTH'(1);
          end else if (!pat_valid_o && cfg_pat_gen_i) begin
            pat_valid_o <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pat_gen_core.sv
// tb/tb_wb_pat_gen_core.sv - table-driven and directed checks for wb_pat_gen_core
module tb_wb_pat_gen_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [11:0] adr = '0;
  logic [1:0]  sel = '0;
  logic [15:0] dat_w = '0;
  logic [15:0] dat_r;
  logic        ack;
  logic        gate = 1'b0;
  logic [15:0] pdata;
  logic        pvalid;
  logic        pready = 1'b0;
  logic        nopg;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  wb_pat_gen_core dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wb_si_cyc_i   (cyc),
    .wb_si_stb_i   (stb),
    .wb_si_we_i    (we),
    .wb_si_adr_i   (adr),
    .wb_si_sel_i   (sel),
    .wb_si_dat_i   (dat_w),
    .wb_si_dat_o   (dat_r),
    .wb_si_ack_o   (ack),
    .cfg_pat_gen_i (gate),
    .pat_data_o    (pdata),
    .pat_valid_o   (pvalid),
    .pat_ready_i   (pready),
    .nopg_o        (nopg)
  );

  typedef struct {
    logic        do_wr;
    logic [11:0] wadr;
    logic [15:0] wdat;
    logic [1:0]  wsel;
    logic [11:0] radr;
    logic [15:0] exp;
  } reg_vec_t;

  reg_vec_t    vt [8];
  logic [15:0] rd;
  logic [15:0] incr_exp [3];
  logic [15:0] walk_exp [3];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [11:0] a, input logic [15:0] d,
                         input logic [1:0] s, output logic [15:0] r);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 8);
    chk($sformatf("ack_latency_%h", a), 16'(n), 16'd1);
    r = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [11:0] a, input logic [15:0] d, input logic [1:0] s);
    logic [15:0] dummy;
    wb_xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_read(input logic [11:0] a, output logic [15:0] r);
    wb_xfer(1'b0, a, 16'h0000, 2'b11, r);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 12'h004, 16'hA5A5, 2'b01, 12'h004, 16'h00A5};
    vt[1] = '{1'b1, 12'h004, 16'h3C5A, 2'b10, 12'h004, 16'h3CA5};
    vt[2] = '{1'b1, 12'h008, 16'h1234, 2'b11, 12'h008, 16'h1234};
    vt[3] = '{1'b1, 12'h01C, 16'hBEEF, 2'b11, 12'h01C, 16'h0000};
    vt[4] = '{1'b1, 12'h104, 16'hFFFF, 2'b11, 12'h004, 16'h3CA5};
    vt[5] = '{1'b1, 12'h00C, 16'hFFFF, 2'b11, 12'h00C, 16'h0000};
    vt[6] = '{1'b1, 12'h000, 16'h0004, 2'b01, 12'h000, 16'h0004};
    vt[7] = '{1'b0, 12'h000, 16'h0000, 2'b00, 12'h204, 16'h0000};
    incr_exp[0] = 16'hFFFE; incr_exp[1] = 16'hFFFF; incr_exp[2] = 16'h0000;
    walk_exp[0] = 16'h0001; walk_exp[1] = 16'h0002; walk_exp[2] = 16'h0004;

    #1;
    chk("rst_valid", 16'(pvalid), 16'd0);
    chk("rst_data", pdata, 16'h0000);
    chk("rst_nopg", 16'(nopg), 16'd1);
    chk("rst_ack", 16'(ack), 16'd0);
    chk("rst_dat_o", dat_r, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vt[i].do_wr) wb_write(vt[i].wadr, vt[i].wdat, vt[i].wsel);
      wb_read(vt[i].radr, rd);
      chk($sformatf("reg_vec%0d", i), rd, vt[i].exp);
    end
    @(negedge clk);
    chk("no_start_without_en", 16'(pvalid), 16'd0);

    // Increment mode, counted run across the wrap
    wb_write(12'h004, 16'hFFFE, 2'b11);
    wb_write(12'h008, 16'h0003, 2'b11);
    pready = 1'b1; gate = 1'b1;
    wb_write(12'h000, 16'h0003, 2'b01);
    chk("start_not_early", 16'(pvalid), 16'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("incr_valid%0d", i), 16'(pvalid), 16'd1);
      chk($sformatf("incr_data%0d", i), pdata, incr_exp[i]);
      @(negedge clk);
    end
    chk("incr_valid_after_done", 16'(pvalid), 16'd0);
    chk("incr_nopg_after_done", 16'(nopg), 16'd1);
    wb_read(12'h00C, rd); chk("incr_status_done", rd, 16'h0002);
    wb_read(12'h000, rd); chk("incr_ctrl_en_cleared", rd, 16'h0002);
    wb_write(12'h00C, 16'h0002, 2'b01);
    wb_read(12'h00C, rd); chk("w1c_done", rd, 16'h0000);

    // Walking-one ignores SEED
    wb_write(12'h004, 16'h0077, 2'b11);
    wb_write(12'h000, 16'h0007, 2'b01);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("walk_data%0d", i), pdata, walk_exp[i]);
      @(negedge clk);
    end
    chk("walk_valid_after_done", 16'(pvalid), 16'd0);
    wb_write(12'h00C, 16'h0002, 2'b01);

    // LFSR with backpressure, then abort
    pready = 1'b0;
    wb_write(12'h004, 16'h0001, 2'b11);
    wb_write(12'h008, 16'h0000, 2'b11);
    wb_write(12'h000, 16'h0005, 2'b01);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("lfsr_hold_valid%0d", i), 16'(pvalid), 16'd1);
      chk($sformatf("lfsr_hold_data%0d", i), pdata, 16'h0001);
      @(negedge clk);
    end
    pready = 1'b1;
    @(negedge clk);
    pready = 1'b0;
    chk("lfsr_next_data", pdata, 16'hB400);
    chk("lfsr_next_valid", 16'(pvalid), 16'd1);
    wb_write(12'h000, 16'h0000, 2'b01);
    chk("abort_still_pending", 16'(pvalid), 16'd1);
    @(negedge clk);
    chk("abort_valid_low", 16'(pvalid), 16'd0);
    wb_read(12'h00C, rd); chk("abort_no_done", rd, 16'h0000);

    // External gate pauses and resumes a continuous run
    wb_write(12'h004, 16'h0010, 2'b11);
    pready = 1'b1; gate = 1'b1;
    wb_write(12'h000, 16'h0003, 2'b01);
    @(negedge clk);
    chk("gate_data0", pdata, 16'h0010);
    @(negedge clk);
    chk("gate_data1", pdata, 16'h0011);
    gate = 1'b0;
    @(negedge clk);
    chk("gate_valid_low", 16'(pvalid), 16'd0);
    chk("gate_nopg", 16'(nopg), 16'd1);
    wb_read(12'h00C, rd); chk("gate_busy", rd, 16'h0001);
    chk("gate_still_low", 16'(pvalid), 16'd0);
    gate = 1'b1;
    #1;
    chk("gate_nopg_reassert", 16'(nopg), 16'd0);
    @(negedge clk);
    chk("gate_resume_valid", 16'(pvalid), 16'd1);
    chk("gate_resume_data", pdata, 16'h0012);
    pready = 1'b0;
    wb_write(12'h000, 16'h0000, 2'b01);
    @(negedge clk);

    // DONE set and W1C on the same edge
    wb_write(12'h004, 16'h0055, 2'b11);
    wb_write(12'h008, 16'h0001, 2'b11);
    wb_write(12'h000, 16'h0001, 2'b01);
    @(negedge clk);
    chk("const_data", pdata, 16'h0055);
    pready = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'h00C; dat_w = 16'h0002; sel = 2'b01;
    @(negedge clk);
    chk("simul_ack", 16'(ack), 16'd1);
    chk("simul_valid_low", 16'(pvalid), 16'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; pready = 1'b0;
    wb_read(12'h00C, rd); chk("simul_done_wins", rd, 16'h0002);
    wb_write(12'h00C, 16'h0002, 2'b01);

    // Asynchronous reset in the middle of a stream
    wb_write(12'h004, 16'h0077, 2'b11);
    wb_write(12'h008, 16'h0000, 2'b11);
    wb_read(12'h004, rd); chk("pre_reset_seed", rd, 16'h0077);
    pready = 1'b1; gate = 1'b1;
    wb_write(12'h000, 16'h0003, 2'b01);
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", 16'(pvalid), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 16'(pvalid), 16'd0);
    chk("arst_data", pdata, 16'h0000);
    chk("arst_nopg", 16'(nopg), 16'd1);
    chk("arst_dat_o", dat_r, 16'h0000);
    chk("arst_ack", 16'(ack), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_read(12'h004, rd); chk("arst_seed", rd, 16'h0000);
    wb_read(12'h000, rd); chk("arst_ctrl", rd, 16'h0000);
    repeat (3) @(negedge clk);
    chk("arst_no_emit", 16'(pvalid), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
